// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file slice.
//   DATA_W_DEF / ADDR_W_DEF / NUM_RD_DEF : default geometry
//   R0_IDX                               : index of the hardwired-zero register
//   port_lsb()                           : bit offset of port p's field inside a
//                                          flattened per-port bus
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int R0_IDX     = 0;

  // Port p's field in a flattened bus starts at p*field_w; use with "+: field_w".
  function automatic int port_lsb(input int p, input int field_w);
    return p * field_w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if
// Bundles the decode/writeback-facing signals of the register file.
//   master : decode + writeback side (drives write, reserve and read indices)
//   slave  : register file side (returns read data, pending bits, scoreboard)
// Per-port fields are flattened: port p uses [p*ADDR_W +: ADDR_W] of rd_addr
// and [p*DATA_W +: DATA_W] of rd_data.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  localparam int NREG = 1 << ADDR_W;

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NREG-1:0]          pend_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_pending, pend_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_pending, pend_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One pending bit per register, set by a reservation from decode and cleared
// by the completing write from writeback.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en/wr_addr   : completing write (clears pending)
//   rsv_en/rsv_addr : new producer (sets pending)
//   pend_d    : next-state scoreboard, so reads can see this edge's update
//   pend_q    : registered scoreboard (drives pend_vec)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(1<<ADDR_W)-1:0]   pend_d,
  output logic [(1<<ADDR_W)-1:0]   pend_q
);

  localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);

  // Release is applied before reserve, so on a same-register collision the
  // new producer wins and the register stays pending. R0 never goes pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != R0_ADDR)) begin
      pend_d[rsv_addr] = 1'b1;
    end
    pend_d[R0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised register file with NUM_RD registered read ports, one write
// port, a hardwired-zero R0 and a per-register pending scoreboard.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears array, scoreboard, read regs)
//   bus  : regfile_if.slave (write, reserve, read indices in; read data,
//          read pending bits and full scoreboard out)
// Build option: define REGFILE_WR_BYPASS_EN to forward a same-edge write to
// any read port addressing the written register; otherwise such a read
// returns the value held before the write.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);

  localparam int                NREG    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);

  logic [DATA_W-1:0]        mem_q [NREG];
  logic [DATA_W-1:0]        mem_d [NREG];
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_d;
  logic [NUM_RD-1:0]        rd_pending_q;
  logic [NUM_RD-1:0]        rd_pending_d;
  logic [NREG-1:0]          pend_d;
  logic [NREG-1:0]          pend_q;
  logic                     wr_live;
  logic [ADDR_W-1:0]        idx;

  // Writes to R0 are dropped here, so mem_q[0] stays zero forever.
  assign wr_live = bus.wr_en && (bus.wr_addr != R0_ADDR);

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .pend_d   (pend_d),
    .pend_q   (pend_q)
  );

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_live) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Pending bits are taken from the next-state scoreboard so a read sees
  // this edge's reserve/release.
  always_comb begin
    rd_data_d    = '0;
    rd_pending_d = '0;
    idx          = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      idx = bus.rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_live && (bus.wr_addr == idx)) begin
        rd_data_d[port_lsb(p, DATA_W) +: DATA_W] = bus.wr_data;
      end else begin
        rd_data_d[port_lsb(p, DATA_W) +: DATA_W] = mem_q[idx];
      end
`else
      rd_data_d[port_lsb(p, DATA_W) +: DATA_W] = mem_q[idx];
`endif
      rd_pending_d[p] = pend_d[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q    <= '0;
      rd_pending_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_q    <= rd_data_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_pending = rd_pending_q;
  assign bus.pend_vec   = pend_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Random plus directed stimulus for regfile_mp (4 read ports, 32x32) against
// a behavioural register-file model; directed steps carry hand-computed
// literal expectations.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 4;
  localparam int NREG = 1 << AW;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: architectural register contents, the set of
  // registers with an outstanding producer, and what each read port shows.
  logic [DW-1:0] m_reg [NREG];
  bit            m_pend [NREG];
  logic [DW-1:0] m_rd [NR];
  bit            m_rdp [NR];

  always @(posedge clk or posedge rst) begin : model
    int a;
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
      for (int p = 0; p < NR; p++) begin
        m_rd[p]  = '0;
        m_rdp[p] = 1'b0;
      end
    end else begin
      if (bus.wr_en) m_pend[bus.wr_addr] = 1'b0;
      if (bus.rsv_en && bus.rsv_addr != 0) m_pend[bus.rsv_addr] = 1'b1;
      for (int p = 0; p < NR; p++) begin
        a = int'(bus.rd_addr[p*AW +: AW]);
        if (a == 0)
          m_rd[p] = '0;
        else if (BYPASS && bus.wr_en && int'(bus.wr_addr) == a)
          m_rd[p] = bus.wr_data;
        else
          m_rd[p] = m_reg[a];
        m_rdp[p] = m_pend[a];
      end
      if (bus.wr_en && bus.wr_addr != 0) m_reg[bus.wr_addr] = bus.wr_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, half a cycle after each edge.
  always @(negedge clk) begin
    logic [NREG-1:0] exp_pv;
    exp_pv = '0;
    for (int i = 0; i < NREG; i++) exp_pv[i] = m_pend[i];
    checkOutput("model_pend_vec", bus.pend_vec, exp_pv);
    for (int p = 0; p < NR; p++) begin
      checkOutput($sformatf("model_rd_data[%0d]", p), bus.rd_data[p*DW +: DW], m_rd[p]);
      checkOutput($sformatf("model_rd_pending[%0d]", p), 32'(bus.rd_pending[p]), 32'(m_rdp[p]));
    end
  end

  // Drive one cycle of inputs, let the next edge consume them, return 2ns later.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic re, input logic [AW-1:0] ra,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = ra;
    bus.rd_addr  = {a3, a2, a1, a0};
    @(posedge clk);
    #2;
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rd_addr = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_rd_data", bus.rd_data[31:0], 32'h0);
    checkOutput("reset_pend_vec", bus.pend_vec, 32'h0);
    @(posedge clk); #2 rst = 1'b0;

    // Write then read on port 1.
    applyStimulus(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0, 0);
    checkOutput("wr_rd_r7_port1", bus.rd_data[1*DW +: DW], 32'hDEADBEEF);

    // R0 discards writes.
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_reads_zero", bus.rd_data, 128'h0);

    // Same-edge write and read of R3.
    applyStimulus(1, 3, 32'h22, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 32'h11, 0, 0, 3, 0, 0, 0);
    checkOutput("same_edge_r3", bus.rd_data[0 +: DW], BYPASS ? 32'h11 : 32'h22);
    applyStimulus(0, 0, 0, 0, 0, 3, 0, 0, 0);
    checkOutput("after_write_r3", bus.rd_data[0 +: DW], 32'h11);

    // Scoreboard priority on R9.
    applyStimulus(0, 0, 0, 1, 9, 0, 0, 9, 0);
    checkOutput("rsv_r9_pending", 32'(bus.rd_pending[2]), 32'h1);
    applyStimulus(1, 9, 32'hAB, 1, 9, 0, 0, 9, 0);
    checkOutput("wr_rsv_r9_pend", bus.pend_vec, 32'h0000_0200);
    applyStimulus(1, 9, 32'hCD, 0, 0, 0, 0, 9, 0);
    checkOutput("release_r9_pend", bus.pend_vec, 32'h0);
    checkOutput("release_r9_rdp", 32'(bus.rd_pending[2]), 32'h0);
    checkOutput("release_r9_data", bus.rd_data[2*DW +: DW], BYPASS ? 32'hCD : 32'hAB);
    applyStimulus(1, 4, 32'h44, 1, 6, 0, 0, 0, 0);
    checkOutput("split_wr_rsv_pend", bus.pend_vec, 32'h0000_0040);

    // Multi-port reads.
    applyStimulus(1, 12, 32'h5A, 1, 2, 0, 0, 0, 0);
    applyStimulus(1, 2, 32'h202, 1, 13, 0, 0, 0, 0);
    applyStimulus(1, 4, 32'h404, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 12, 12, 12, 12);
    checkOutput("all_ports_r12", bus.rd_data, {4{32'h5A}});
    checkOutput("all_ports_r12_p", 32'(bus.rd_pending), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 2, 6, 13, 4);
    checkOutput("distinct_data", bus.rd_data, {32'h404, 32'h0, 32'h0, 32'h202});
    checkOutput("distinct_pending", 32'(bus.rd_pending), 32'b0110);

    // Randomized traffic, checked by the model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), pick(), $urandom(),
                    ($urandom_range(0, 3) == 0), pick(), pick(), pick(), pick(), pick());
    end

    // Reset mid-run with pending set.
    applyStimulus(1, 5, 32'h55, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5, 5, 5, 5, 5);
    checkOutput("pre_reset_pending", 32'(bus.rd_pending), 32'hF);
    bus.rsv_en = 1'b0;
    bus.wr_en  = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rd_data", bus.rd_data, 128'h0);
    checkOutput("midrst_rd_pending", 32'(bus.rd_pending), 32'h0);
    checkOutput("midrst_pend_vec", bus.pend_vec, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 5, 5, 5, 5);
    checkOutput("post_rst_r5", bus.rd_data[0 +: DW], 32'h0);
    checkOutput("post_rst_r5_p", 32'(bus.rd_pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
